// File: rtl/uart_rx_word_packer_pkg.sv
// Shared definitions for the UART receive word packer: CPU register
// offsets, STATUS bit positions and STATUS control-write bit positions.
package uart_pkg;

  typedef logic [31:0] word_t;

  localparam logic [2:0] ADDR_DATA   = 3'h0;
  localparam logic [2:0] ADDR_STATUS = 3'h4;

  localparam int ST_NEMPTY   = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVR      = 2;
  localparam int ST_TMO      = 3;
  localparam int ST_BCNT_LSB = 4;
  localparam int ST_WCNT_LSB = 8;

  localparam int CTL_FLUSH   = 0;
  localparam int CTL_CLR_OVR = 2;
  localparam int CTL_CLR_TMO = 3;

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Bus bundle between the byte receiver / CPU side (master) and the word
// packer (slave): received-byte strobe plus the memory-mapped CPU window.
interface uart_rx_word_packer_if;
  import uart_pkg::*;

  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic [15:0] address;
  logic        we;
  logic        rd;
  word_t       w_data;
  word_t       r_data;
  logic        word_ready;
  logic        overrun;

  modport master (
    output rx_done_tick, rx_data, address, we, rd, w_data,
    input  r_data, word_ready, overrun
  );

  modport slave (
    input  rx_done_tick, rx_data, address, we, rd, w_data,
    output r_data, word_ready, overrun
  );

endinterface

// File: rtl/uart_rx_word_packer_word_fifo.sv
// Parameterised synchronous FIFO of 32-bit words. A pop on an empty FIFO
// is ignored; a push when full only lands if a pop frees a slot on the
// same edge, otherwise it is dropped and the FIFO is left untouched.
module word_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  word_t                    din,
  output word_t                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array: written only when a push is accepted, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs four received UART bytes (little-endian) into a 32-bit word, queues
// words in word_fifo and exposes DATA (0x0) / STATUS (0x4) registers.
// Optional build macro UART_RX_TIMEOUT_EN adds an idle timeout that
// discards a partial word and raises the STATUS timeout flag.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_word_packer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic          overrun_q;
  logic          timeout_q;
  logic          sel_data;
  logic          sel_status;
  logic          status_wr;
  logic          flush;
  logic          pop_req;
  logic          push;
  logic          timeout_fire;
  logic          set_ovr;
  word_t         head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          unused_bits;

  assign sel_data   = (bus.address[2:0] == ADDR_DATA);
  assign sel_status = (bus.address[2:0] == ADDR_STATUS);
  assign status_wr  = bus.we && sel_status;
  assign flush      = status_wr && bus.w_data[CTL_FLUSH];
  assign pop_req    = bus.rd && sel_data;
  assign push       = bus.rx_done_tick && (byte_cnt == 2'd3) && !flush && !timeout_fire;
  assign set_ovr    = push && full && !pop_req;

  assign unused_bits = ^{bus.address[15:3], bus.w_data[31:4], bus.w_data[1]};

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   ({bus.rx_data, shift}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_fire = (byte_cnt != 2'd0) && !bus.rx_done_tick &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: restarts on every byte and only runs while a word is partial.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (bus.rx_done_tick || byte_cnt == 2'd0 || flush || timeout_fire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  logic [31:0] unused_tmo_cfg;

  assign unused_tmo_cfg = TIMEOUT_CYCLES;
  assign timeout_fire   = 1'b0;
`endif

  // Byte packer: a flush or timeout beats an incoming byte on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      shift    <= '0;
    end else if (flush || timeout_fire) begin
      byte_cnt <= 2'd0;
      shift    <= '0;
    end else if (bus.rx_done_tick) begin
      if (byte_cnt == 2'd3) begin
        byte_cnt <= 2'd0;
        shift    <= '0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    shift[7:0]   <= bus.rx_data;
          2'd1:    shift[15:8]  <= bus.rx_data;
          2'd2:    shift[23:16] <= bus.rx_data;
          default: shift        <= shift;
        endcase
      end
    end
  end

  // Sticky flags: a set event on the same edge as a CPU clear keeps the flag high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_ovr) begin
        overrun_q <= 1'b1;
      end else if (status_wr && bus.w_data[CTL_CLR_OVR]) begin
        overrun_q <= 1'b0;
      end
      if (timeout_fire) begin
        timeout_q <= 1'b1;
      end else if (status_wr && bus.w_data[CTL_CLR_TMO]) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Read mux: DATA shows the FIFO head (0 when empty), STATUS the flags.
  always_comb begin
    bus.r_data = '0;
    case (bus.address[2:0])
      ADDR_DATA: begin
        if (!empty) begin
          bus.r_data = head;
        end
      end
      ADDR_STATUS: begin
        bus.r_data[ST_NEMPTY]             = !empty;
        bus.r_data[ST_FULL]               = full;
        bus.r_data[ST_OVR]                = overrun_q;
        bus.r_data[ST_TMO]                = timeout_q;
        bus.r_data[ST_BCNT_LSB +: 2]      = byte_cnt;
        bus.r_data[ST_WCNT_LSB +: CW]     = count;
      end
      default: bus.r_data = '0;
    endcase
  end

  assign bus.word_ready = !empty;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer (DEPTH=4, TIMEOUT_CYCLES=100).
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_uart_rx_word_packer;
  import uart_pkg::*;

  typedef struct {
    logic        tick;
    logic [7:0]  data;
    logic [15:0] addr;
    logic        we;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_ovr;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_rx_word_packer_if bus ();

  uart_rx_word_packer #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.rx_done_tick = v.tick;
    bus.rx_data      = v.data;
    bus.address      = v.addr;
    bus.we           = v.we;
    bus.rd           = v.rd;
    bus.w_data       = v.wdata;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.we           = 1'b0;
    bus.rd           = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("vec%0d_rdata", idx), bus.r_data, v.exp_rdata);
    checkValue($sformatf("vec%0d_ready", idx), {31'd0, bus.word_ready}, {31'd0, v.exp_ready});
    checkValue($sformatf("vec%0d_ovr", idx), {31'd0, bus.overrun}, {31'd0, v.exp_ovr});
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic writeStatus(input logic [31:0] val);
    @(negedge clk);
    bus.address = 16'h0004;
    bus.we      = 1'b1;
    bus.w_data  = val;
    @(negedge clk);
    bus.we      = 1'b0;
  endtask

  task automatic popWord();
    @(negedge clk);
    bus.address = 16'h0000;
    bus.rd      = 1'b1;
    @(negedge clk);
    bus.rd      = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] a, output logic [31:0] val);
    bus.address = a;
    #1;
    val = bus.r_data;
  endtask

  vec_t vecs [19];

  initial begin
    logic [31:0] rv;
    checks = 0;
    errors = 0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.address      = 16'h0004;
    bus.we           = 1'b0;
    bus.rd           = 1'b0;
    bus.w_data       = 32'h0;

    //              tick  data   addr     we    rd    wdata          exp_rdata      rdy   ovr
    vecs[0]  = '{1'b1, 8'h11, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0020, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0030, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 16'h0000, 1'b0, 1'b0, 32'h0,        32'h4433_2211, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0101, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hA0, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'hA1, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0020, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 16'h0004, 1'b1, 1'b0, 32'h1,        32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'hAA, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'hBB, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0020, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'hCC, 16'h0004, 1'b0, 1'b0, 32'h0,        32'h0000_0030, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'hDD, 16'h0000, 1'b0, 1'b0, 32'h0,        32'hDDCC_BBAA, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h55, 16'h0004, 1'b1, 1'b0, 32'h1,        32'h0000_0000, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 16'h0002, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    readReg(16'h0004, rv);
    checkValue("reset_status", rv, 32'h0);
    readReg(16'h0000, rv);
    checkValue("reset_data", rv, 32'h0);
    checkValue("reset_ready", {31'd0, bus.word_ready}, 32'h0);
    checkValue("reset_ovr", {31'd0, bus.overrun}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    $display("[TB] overrun sequence");
    for (int i = 0; i < 20; i++) begin
      sendByte(8'(i));
    end
    @(negedge clk);
    readReg(16'h0004, rv);
    checkValue("ovr_status", rv, 32'h0000_0407);
    checkValue("ovr_flag", {31'd0, bus.overrun}, 32'h1);
    writeStatus(32'h4);
    readReg(16'h0004, rv);
    checkValue("ovr_cleared_status", rv, 32'h0000_0403);
    checkValue("ovr_cleared_flag", {31'd0, bus.overrun}, 32'h0);

    $display("[TB] push and pop on a full fifo");
    sendByte(8'h20);
    sendByte(8'h21);
    sendByte(8'h22);
    readReg(16'h0004, rv);
    checkValue("full_partial_status", rv, 32'h0000_0433);
    readReg(16'h0000, rv);
    checkValue("full_head_before", rv, 32'h0302_0100);
    @(negedge clk);
    bus.address      = 16'h0000;
    bus.rd           = 1'b1;
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = 8'h23;
    @(negedge clk);
    bus.rd           = 1'b0;
    bus.rx_done_tick = 1'b0;
    readReg(16'h0004, rv);
    checkValue("full_pushpop_status", rv, 32'h0000_0403);
    readReg(16'h0000, rv);
    checkValue("drain_w1", rv, 32'h0706_0504);
    popWord();
    readReg(16'h0000, rv);
    checkValue("drain_w2", rv, 32'h0B0A_0908);
    popWord();
    readReg(16'h0000, rv);
    checkValue("drain_w3", rv, 32'h0F0E_0D0C);
    popWord();
    readReg(16'h0000, rv);
    checkValue("drain_new", rv, 32'h2322_2120);
    popWord();
    readReg(16'h0004, rv);
    checkValue("drain_empty_status", rv, 32'h0);

    $display("[TB] idle timeout");
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    repeat (105) @(negedge clk);
    readReg(16'h0004, rv);
`ifdef UART_RX_TIMEOUT_EN
    checkValue("timeout_status", rv, 32'h0000_0008);
`else
    checkValue("no_timeout_status", rv, 32'h0000_0030);
`endif
    checkValue("timeout_ready", {31'd0, bus.word_ready}, 32'h0);
    writeStatus(32'h9);
    readReg(16'h0004, rv);
    checkValue("timeout_cleared", rv, 32'h0);

    $display("[TB] async reset mid-word");
    sendByte(8'h61);
    sendByte(8'h62);
    sendByte(8'h63);
    sendByte(8'h64);
    sendByte(8'h65);
    sendByte(8'h66);
    readReg(16'h0004, rv);
    checkValue("pre_reset_status", rv, 32'h0000_0121);
    readReg(16'h0000, rv);
    checkValue("pre_reset_data", rv, 32'h6463_6261);
    #2;
    reset = 1'b1;
    #1;
    checkValue("async_reset_data", bus.r_data, 32'h0);
    checkValue("async_reset_ready", {31'd0, bus.word_ready}, 32'h0);
    readReg(16'h0004, rv);
    checkValue("async_reset_status", rv, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    readReg(16'h0004, rv);
    checkValue("post_reset_status", rv, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
